// File: rtl/mapper_symbol_sequencer_if.sv
// Word-in / symbol-out handshake bundle for the symbol sequencer.
// slave = sequencer side, master = word source / symbol sink side.
interface mapper_symbol_sequencer_if #(
  parameter int INPUT_DATA_WIDTH = 12,
  parameter int SCHEME_WIDTH     = 4
);
  logic                        in_valid;
  logic                        in_ready;
  logic [INPUT_DATA_WIDTH-1:0] in_data;
  logic [SCHEME_WIDTH-1:0]     in_scheme;
  logic                        out_valid;
  logic                        out_ready;
  logic [5:0]                  out_bits;
  logic [SCHEME_WIDTH-1:0]     out_scheme;
  logic [3:0]                  out_index;
  logic                        out_last;
  logic                        out_rot;
  logic                        err_scheme;
  logic                        busy;

  modport slave (
    input  in_valid, in_data, in_scheme, out_ready,
    output in_ready, out_valid, out_bits, out_scheme,
    output out_index, out_last, out_rot, err_scheme, busy
  );

  modport master (
    output in_valid, in_data, in_scheme, out_ready,
    input  in_ready, out_valid, out_bits, out_scheme,
    input  out_index, out_last, out_rot, err_scheme, busy
  );
endinterface

// File: rtl/mapper_symbol_sequencer.sv
// Splits a 12-bit word into MSB-first symbols of 1/2/4/6 bits,
// one symbol per cycle, with zero-bubble word chaining.
module mapper_symbol_sequencer #(
  parameter int INPUT_DATA_WIDTH = 12,
  parameter int SCHEME_WIDTH     = 4
) (
  input logic                      clk,
  input logic                      rst,
  mapper_symbol_sequencer_if.slave bus
);
  localparam int W = INPUT_DATA_WIDTH;
  localparam int S = SCHEME_WIDTH;

  localparam logic [S-1:0] SC_PB2   = S'(1);
  localparam logic [S-1:0] SC_BPSK  = S'(2);
  localparam logic [S-1:0] SC_QPSK  = S'(3);
  localparam logic [S-1:0] SC_QAM16 = S'(4);
  localparam logic [S-1:0] SC_QAM64 = S'(5);

  typedef enum logic {IDLE, EMIT} state_t;

  state_t       r_state, w_state;
  logic [W-1:0] r_sh, w_sh;
  logic         r_valid, w_valid;
  logic [5:0]   r_bits, w_bits;
  logic [S-1:0] r_scheme, w_scheme;
  logic [3:0]   r_index, w_index;
  logic         r_last, w_last;
  logic         r_rot, w_rot;
  logic         r_err, w_err;

  logic         w_hs;
  logic         w_rdy;
  logic         w_acc;
  logic         w_legal;
  logic [3:0]   w_nxt_idx;

  function automatic logic f_legal(input logic [S-1:0] s);
    case (s)
      SC_PB2, SC_BPSK, SC_QPSK,
      SC_QAM16, SC_QAM64: f_legal = 1'b1;
      default:            f_legal = 1'b0;
    endcase
  endfunction

  // Leading symbol of the (remaining) word, right-justified.
  function automatic logic [5:0] f_top(
    input logic [W-1:0] w,
    input logic [S-1:0] s
  );
    case (s)
      SC_PB2,
      SC_BPSK:  f_top = {5'b0, w[W-1]};
      SC_QPSK:  f_top = {4'b0, w[W-1 -: 2]};
      SC_QAM16: f_top = {2'b0, w[W-1 -: 4]};
      SC_QAM64: f_top = w[W-1 -: 6];
      default:  f_top = 6'b0;
    endcase
  endfunction

  function automatic logic [W-1:0] f_shift(
    input logic [W-1:0] w,
    input logic [S-1:0] s
  );
    case (s)
      SC_PB2,
      SC_BPSK:  f_shift = w << 1;
      SC_QPSK:  f_shift = w << 2;
      SC_QAM16: f_shift = w << 4;
      SC_QAM64: f_shift = w << 6;
      default:  f_shift = w;
    endcase
  endfunction

  function automatic logic [3:0] f_lastidx(input logic [S-1:0] s);
    case (s)
      SC_PB2,
      SC_BPSK:  f_lastidx = 4'd11;
      SC_QPSK:  f_lastidx = 4'd5;
      SC_QAM16: f_lastidx = 4'd2;
      SC_QAM64: f_lastidx = 4'd1;
      default:  f_lastidx = 4'd0;
    endcase
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= IDLE;
      r_sh     <= '0;
      r_valid  <= 1'b0;
      r_bits   <= '0;
      r_scheme <= '0;
      r_index  <= '0;
      r_last   <= 1'b0;
      r_rot    <= 1'b0;
      r_err    <= 1'b0;
    end else begin
      r_state  <= w_state;
      r_sh     <= w_sh;
      r_valid  <= w_valid;
      r_bits   <= w_bits;
      r_scheme <= w_scheme;
      r_index  <= w_index;
      r_last   <= w_last;
      r_rot    <= w_rot;
      r_err    <= w_err;
    end
  end

  always_comb begin
    w_state   = r_state;
    w_sh      = r_sh;
    w_valid   = r_valid;
    w_bits    = r_bits;
    w_scheme  = r_scheme;
    w_index   = r_index;
    w_last    = r_last;
    w_rot     = r_rot;
    w_hs      = r_valid & bus.out_ready;
    w_rdy     = (r_state == IDLE) | (w_hs & r_last);
    w_acc     = bus.in_valid & w_rdy;
    w_legal   = f_legal(bus.in_scheme);
    w_err     = w_acc & ~w_legal;
    w_nxt_idx = r_index + 4'd1;

    // A new legal word overrides the end-of-word return to idle.
    if (w_acc && w_legal) begin
      w_state  = EMIT;
      w_valid  = 1'b1;
      w_scheme = bus.in_scheme;
      w_bits   = f_top(bus.in_data, bus.in_scheme);
      w_sh     = f_shift(bus.in_data, bus.in_scheme);
      w_index  = 4'd0;
      w_last   = 1'b0;
      w_rot    = 1'b0;
    end else if (w_hs) begin
      if (r_last) begin
        w_state = IDLE;
        w_valid = 1'b0;
        w_bits  = '0;
        w_sh    = '0;
        w_index = '0;
        w_last  = 1'b0;
        w_rot   = 1'b0;
      end else begin
        w_bits  = f_top(r_sh, r_scheme);
        w_sh    = f_shift(r_sh, r_scheme);
        w_index = w_nxt_idx;
        w_last  = (w_nxt_idx == f_lastidx(r_scheme));
        w_rot   = (r_scheme == SC_PB2) & w_nxt_idx[0];
      end
    end
  end

  assign bus.in_ready   = w_rdy & ~rst;
  assign bus.out_valid  = r_valid;
  assign bus.out_bits   = r_bits;
  assign bus.out_scheme = r_scheme;
  assign bus.out_index  = r_index;
  assign bus.out_last   = r_last;
  assign bus.out_rot    = r_rot;
  assign bus.err_scheme = r_err;
  assign bus.busy       = (r_state == EMIT);
endmodule

// File: tb/tb_mapper_symbol_sequencer.sv
// Directed and random checks of mapper_symbol_sequencer against
// a queue-of-symbols reference model.
module tb_mapper_symbol_sequencer;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  mapper_symbol_sequencer_if #(
    .INPUT_DATA_WIDTH(12),
    .SCHEME_WIDTH(4)
  ) bus ();

  mapper_symbol_sequencer #(
    .INPUT_DATA_WIDTH(12),
    .SCHEME_WIDTH(4)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  typedef struct {
    logic [5:0] bits;
    logic [3:0] sch;
    logic [3:0] idx;
    logic       last;
    logic       rot;
  } sym_t;

  sym_t       q[$];
  logic [5:0] log_q[$];
  logic [3:0] m_sch = 4'd0;
  bit         m_err = 1'b0;
  int         checks = 0;
  int         errors = 0;

  task automatic check(input string tag, input logic [15:0] obs,
                       input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int bps(input logic [3:0] s);
    case (s)
      4'd1, 4'd2: return 1;
      4'd3:       return 2;
      4'd4:       return 4;
      4'd5:       return 6;
      default:    return 0;
    endcase
  endfunction

  // Symbol k = bits [11-k*b : 12-(k+1)*b] of the word.
  task automatic push_word(input logic [11:0] d, input logic [3:0] s);
    int b;
    int n;
    sym_t y;
    b = bps(s);
    n = 12 / b;
    for (int k = 0; k < n; k++) begin
      y.bits = 6'((int'(d) >> (12 - (k + 1) * b)) & ((1 << b) - 1));
      y.sch  = s;
      y.idx  = 4'(k);
      y.last = (k == n - 1);
      y.rot  = (s == 4'd1) ? 1'(k % 2) : 1'b0;
      q.push_back(y);
    end
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_valid"}, 16'(bus.out_valid), 16'd0);
    check({tag, "_bits"}, 16'(bus.out_bits), 16'd0);
    check({tag, "_scheme"}, 16'(bus.out_scheme), 16'd0);
    check({tag, "_index"}, 16'(bus.out_index), 16'd0);
    check({tag, "_last"}, 16'(bus.out_last), 16'd0);
    check({tag, "_rot"}, 16'(bus.out_rot), 16'd0);
    check({tag, "_err"}, 16'(bus.err_scheme), 16'd0);
    check({tag, "_busy"}, 16'(bus.busy), 16'd0);
    check({tag, "_in_ready"}, 16'(bus.in_ready), 16'd0);
  endtask

  task automatic step(input bit v, input logic [11:0] d,
                      input logic [3:0] s, input bit ordy,
                      output bit acc);
    bit   er;
    bit   ev;
    sym_t f;
    @(negedge clk);
    bus.in_valid  = v;
    bus.in_data   = d;
    bus.in_scheme = s;
    bus.out_ready = ordy;
    #1;
    ev = (q.size() != 0);
    if (ev) f = q[0];
    else begin
      f.bits = 0; f.idx = 0; f.last = 0; f.rot = 0; f.sch = m_sch;
    end
    check("out_valid", 16'(bus.out_valid), 16'(ev));
    check("out_bits", 16'(bus.out_bits), 16'(f.bits));
    check("out_scheme", 16'(bus.out_scheme), 16'(f.sch));
    check("out_index", 16'(bus.out_index), 16'(f.idx));
    check("out_last", 16'(bus.out_last), 16'(f.last));
    check("out_rot", 16'(bus.out_rot), 16'(f.rot));
    check("err_scheme", 16'(bus.err_scheme), 16'(m_err));
    check("busy", 16'(bus.busy), 16'(ev));
    er = (q.size() == 0) || (ordy && q.size() == 1);
    check("in_ready", 16'(bus.in_ready), 16'(er));
    acc = v && er;
    if (ev && ordy) begin
      log_q.push_back(bus.out_bits);
      void'(q.pop_front());
    end
    m_err = acc && (bps(s) == 0);
    if (acc && bps(s) != 0) begin
      push_word(d, s);
      m_sch = s;
    end
  endtask

  task automatic offer(input logic [11:0] d, input logic [3:0] s);
    bit acc = 1'b0;
    int t = 0;
    while (!acc && t < 60) begin
      step(1'b1, d, s, 1'b1, acc);
      t++;
    end
    check("offer_timeout", 16'(acc), 16'd1);
  endtask

  task automatic drain();
    bit acc;
    int t = 0;
    while (q.size() != 0 && t < 100) begin
      step(1'b0, 12'd0, 4'd0, 1'b1, acc);
      t++;
    end
    check("drain_timeout", 16'(q.size()), 16'd0);
    step(1'b0, 12'd0, 4'd0, 1'b1, acc);
  endtask

  task automatic check_log(input string tag, input logic [5:0] e[$]);
    check({tag, "_count"}, 16'(log_q.size()), 16'(e.size()));
    for (int i = 0; i < e.size() && i < log_q.size(); i++)
      check(tag, 16'(log_q[i]), 16'(e[i]));
    log_q.delete();
  endtask

  initial begin
    bit         acc;
    logic [5:0] e[$];
    bus.in_valid  = 1'b1;
    bus.in_data   = 12'hfff;
    bus.in_scheme = 4'd3;
    bus.out_ready = 1'b1;
    #1;
    check_zero("reset");
    repeat (2) @(negedge clk);
    rst = 1'b0;
    bus.in_valid = 1'b0;

    offer(12'b101101110111, 4'd3);
    drain();
    e = '{2, 3, 1, 3, 1, 3};
    check_log("qpsk", e);

    offer(12'b101010101010, 4'd2);
    offer(12'b101010101010, 4'd5);
    drain();
    e = '{1, 0, 1, 0, 1, 0, 1, 0, 1, 0, 1, 0, 42, 42};
    check_log("b2b", e);

    offer(12'b110010101011, 4'd1);
    drain();
    e = '{1, 1, 0, 0, 1, 0, 1, 0, 1, 0, 1, 1};
    check_log("pb2", e);

    offer(12'b010110100110, 4'd4);
    step(1'b0, 12'd0, 4'd0, 1'b1, acc);
    repeat (3) step(1'b0, 12'd0, 4'd0, 1'b0, acc);
    drain();
    e = '{5, 10, 6};
    check_log("qam16", e);

    offer(12'habc, 4'd7);
    step(1'b0, 12'd0, 4'd0, 1'b1, acc);
    step(1'b0, 12'd0, 4'd0, 1'b1, acc);
    offer(12'b000001111111, 4'd5);
    drain();
    e = '{1, 63};
    check_log("qam64", e);

    offer(12'b011011000110, 4'd3);
    step(1'b0, 12'd0, 4'd0, 1'b1, acc);
    step(1'b0, 12'd0, 4'd0, 1'b1, acc);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check_zero("midrst");
    q.delete();
    log_q.delete();
    m_sch = 4'd0;
    m_err = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    repeat (4) step(1'b0, 12'd0, 4'd0, 1'b1, acc);
    check("midrst_log", 16'(log_q.size()), 16'd0);

    for (int i = 0; i < 600; i++) begin
      step(($urandom_range(0, 9) < 7),
           12'($urandom),
           4'($urandom_range(0, 7)),
           ($urandom_range(0, 3) != 0), acc);
    end
    drain();

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end
endmodule
